// File: rtl/zap_cp15_pkg.sv
// Shared CP15 transfer definitions: FSM encodings, instruction field positions,
// match patterns, decode result type and the mode-banked register translation.
package zap_cp15_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CRN_LSB = 16;
  localparam int RD_LSB  = 12;
  localparam int CP_LSB  = 8;
  localparam int L_BIT   = 20;

  // MCR/MRC and CDP share [27:24]; bit 4 tells them apart.
  localparam logic [3:0] CPXFER_OP  = 4'b1110;
  localparam logic [2:0] LDC_STC_OP = 3'b110;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  typedef struct packed {
    logic       supported;
    logic       is_mrc;
    logic [3:0] crn;
    logic [3:0] rd;
  } cp_decode_t;

  // Physical map: 0-15 user/system, 16-22 FIQ R8-R14, then R13/R14 pairs
  // for IRQ (23), SVC (25), ABT (27), UND (29).
  function automatic logic [5:0] translate(input logic [3:0] rd, input logic [4:0] mode);
    logic [5:0] r;
    r = {2'b00, rd};
    case (mode)
      MODE_FIQ: if (rd >= 4'd8 && rd <= 4'd14) r = r + 6'd8;
      MODE_IRQ: if (rd == 4'd13 || rd == 4'd14) r = r + 6'd10;
      MODE_SVC: if (rd == 4'd13 || rd == 4'd14) r = r + 6'd12;
      MODE_ABT: if (rd == 4'd13 || rd == 4'd14) r = r + 6'd14;
      MODE_UND: if (rd == 4'd13 || rd == 4'd14) r = r + 6'd16;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zap_cp15_decode.sv
// Combinational classifier for a coprocessor instruction word: only MCR/MRC
// addressed to CP_NUM is supported; CDP, LDC/STC and other numbers are not.
module zap_cp15_decode
  import zap_cp15_pkg::*;
#(
  parameter logic [3:0] CP_NUM = 4'd15
) (
  input  logic [31:0] word_i,
  output cp_decode_t  dec_o
);

  logic is_xfer;
  logic is_cdp;
  logic is_ldst;
  logic cp_match;
  logic unused_bits;

  always_comb begin
    is_xfer  = (word_i[27:24] == CPXFER_OP) && word_i[4];
    is_cdp   = (word_i[27:24] == CPXFER_OP) && !word_i[4];
    is_ldst  = (word_i[27:25] == LDC_STC_OP);
    cp_match = (word_i[CP_LSB +: 4] == CP_NUM);

    dec_o.supported = is_xfer && !is_cdp && !is_ldst && cp_match;
    dec_o.is_mrc    = word_i[L_BIT];
    dec_o.crn       = word_i[CRN_LSB +: 4];
    dec_o.rd        = word_i[RD_LSB +: 4];
  end

  // Condition, opcode1/2 and CRm have no effect on this bank.
  assign unused_bits = ^{word_i[31:28], word_i[23:21], word_i[7:5], word_i[3:0]};

endmodule

// File: rtl/zap_cp15_xfer.sv
// CP15 MCR/MRC transfer engine with an internal 16x32 register bank.
// Optional feature macro: ZAP_CP15_XFER_UNDEF_EN (o_undef pulses for unsupported ops).
//
// state  | meaning
// IDLE   | waiting for i_copro_dav; decode and launch register-file access
// XFER   | register-file request cycle (MRC write / MCR read)
// CAPT   | MCR read data returns; update CR[CRn]
// DONE   | o_copro_done high for one cycle
module zap_cp15_xfer
  import zap_cp15_pkg::*;
#(
  parameter int          PHY_REGS   = 46,
  parameter logic [3:0]  CP_NUM     = 4'd15,
  parameter logic [31:0] CP_ID      = 32'h4107_0000,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0078
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_copro_dav,
  input  logic [31:0]                 i_copro_word,
  input  logic [4:0]                  i_cpsr_mode,
  output logic                        o_copro_done,
  output logic                        o_reg_en,
  output logic                        o_reg_wr,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_index,
  output logic [31:0]                 o_reg_wr_data,
  input  logic [31:0]                 i_reg_rd_data,
  output logic [31:0]                 o_cp_ctrl,
  output logic                        o_cp_wr_stb,
  output logic [3:0]                  o_cp_wr_idx,
  output logic                        o_undef
);

  localparam int IDX_W = $clog2(PHY_REGS);

  cp_decode_t       dec;
  logic [1:0]       state_q, state_d;
  logic [3:0]       crn_q;
  logic             is_mrc_q;
  logic [31:0]      cr_q [16];
  logic             reg_en_q;
  logic             reg_wr_q;
  logic [IDX_W-1:0] reg_index_q;
  logic [31:0]      reg_wr_data_q;
  logic             done_q;
  logic             wr_stb_q;
  logic [3:0]       wr_idx_q;

  zap_cp15_decode #(.CP_NUM(CP_NUM)) u_decode (
    .word_i (i_copro_word),
    .dec_o  (dec)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_copro_dav) state_d = dec.supported ? S_XFER : S_DONE;
      S_XFER: state_d = is_mrc_q ? S_DONE : S_CAPT;
      S_CAPT: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a flop loaded one edge ahead so it lines up with the state it belongs to.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      crn_q         <= 4'd0;
      is_mrc_q      <= 1'b0;
      reg_en_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_index_q   <= '0;
      reg_wr_data_q <= 32'd0;
      done_q        <= 1'b0;
      wr_stb_q      <= 1'b0;
      wr_idx_q      <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        cr_q[i] <= (i == 0) ? CP_ID : (i == 1) ? CTRL_RESET : 32'd0;
      end
    end else begin
      state_q  <= state_d;
      done_q   <= 1'b0;
      wr_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_copro_dav) begin
            crn_q       <= dec.crn;
            is_mrc_q    <= dec.is_mrc;
            reg_index_q <= IDX_W'(translate(dec.rd, i_cpsr_mode));
            if (dec.supported) begin
              // An MRC targeting R15 completes without touching the register file.
              reg_en_q <= !(dec.is_mrc && dec.rd == 4'd15);
              reg_wr_q <= dec.is_mrc;
              if (dec.is_mrc) reg_wr_data_q <= cr_q[dec.crn];
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_XFER: begin
          reg_en_q <= 1'b0;
          reg_wr_q <= 1'b0;
          if (is_mrc_q) done_q <= 1'b1;
        end
        S_CAPT: begin
          if (crn_q != 4'd0) begin
            cr_q[crn_q] <= i_reg_rd_data;
            wr_stb_q    <= 1'b1;
            wr_idx_q    <= crn_q;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ZAP_CP15_XFER_UNDEF_EN
  logic undef_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      undef_q <= 1'b0;
    end else begin
      undef_q <= (state_q == S_IDLE) && i_copro_dav && !dec.supported;
    end
  end

  assign o_undef = undef_q;
`else
  assign o_undef = 1'b0;
`endif

  assign o_copro_done  = done_q;
  assign o_reg_en      = reg_en_q;
  assign o_reg_wr      = reg_wr_q;
  assign o_reg_index   = reg_index_q;
  assign o_reg_wr_data = reg_wr_data_q;
  assign o_cp_ctrl     = cr_q[1];
  assign o_cp_wr_stb   = wr_stb_q;
  assign o_cp_wr_idx   = wr_idx_q;

endmodule

// File: tb/tb_zap_cp15_xfer.sv
// Directed bench for zap_cp15_xfer: vector table plus hand-written reset/dav corner cases.
module tb_zap_cp15_xfer;
  import zap_cp15_pkg::*;

  localparam logic [31:0] CP_ID = 32'h4107_0000;
  localparam logic [31:0] CTRL0 = 32'h0000_0078;
`ifdef ZAP_CP15_XFER_UNDEF_EN
  localparam logic UNDEF_EXP = 1'b1;
`else
  localparam logic UNDEF_EXP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_copro_dav = 1'b0;
  logic [31:0] i_copro_word = 32'd0;
  logic [4:0]  i_cpsr_mode = 5'b10000;
  logic [31:0] i_reg_rd_data = 32'd0;
  logic        o_copro_done, o_reg_en, o_reg_wr, o_cp_wr_stb, o_undef;
  logic [5:0]  o_reg_index;
  logic [31:0] o_reg_wr_data, o_cp_ctrl;
  logic [3:0]  o_cp_wr_idx;

  int checks = 0;
  int errors = 0;

  zap_cp15_xfer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_copro_dav   (i_copro_dav),
    .i_copro_word  (i_copro_word),
    .i_cpsr_mode   (i_cpsr_mode),
    .o_copro_done  (o_copro_done),
    .o_reg_en      (o_reg_en),
    .o_reg_wr      (o_reg_wr),
    .o_reg_index   (o_reg_index),
    .o_reg_wr_data (o_reg_wr_data),
    .i_reg_rd_data (i_reg_rd_data),
    .o_cp_ctrl     (o_cp_ctrl),
    .o_cp_wr_stb   (o_cp_wr_stb),
    .o_cp_wr_idx   (o_cp_wr_idx),
    .o_undef       (o_undef)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] word;
    logic [4:0]  mode;
    logic [31:0] rd_data;
    int          lat;
    int          en;
    logic        wr;
    logic [5:0]  idx;
    logic [31:0] wdata;
    int          stb;
    logic [3:0]  sidx;
    logic        undef;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mrc(input logic [3:0] crn, input logic [3:0] rd);
    return {8'hEE, 3'b000, 1'b1, crn, rd, 4'hF, 8'h10};
  endfunction

  function automatic logic [31:0] mcr(input logic [3:0] crn, input logic [3:0] rd);
    return {8'hEE, 3'b000, 1'b0, crn, rd, 4'hF, 8'h10};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input bit drop_early);
    int          lat = 0;
    int          en_cnt = 0;
    int          stb_cnt = 0;
    logic        wr_c = 1'b0;
    logic [5:0]  idx_c = '0;
    logic [31:0] wd_c = '0;
    logic [3:0]  sidx_c = '0;
    logic        und_c = 1'b0;
    bit          got = 0;
    i_copro_word  = v.word;
    i_cpsr_mode   = v.mode;
    i_reg_rd_data = v.rd_data;
    i_copro_dav   = 1'b1;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge i_clk); #1;
      if (drop_early) i_copro_dav = 1'b0;
      if (o_reg_en) begin
        en_cnt++;
        wr_c  = o_reg_wr;
        idx_c = o_reg_index;
        wd_c  = o_reg_wr_data;
      end
      if (o_cp_wr_stb) begin
        stb_cnt++;
        sidx_c = o_cp_wr_idx;
      end
      if (o_copro_done) begin
        got = 1;
        lat = c;
        und_c = o_undef;
        i_copro_dav = 1'b0;
      end
    end
    if (!got) i_copro_dav = 1'b0;
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " reg_en count"}, en_cnt, v.en);
    if (v.en != 0) begin
      check({v.name, " reg_wr"}, {31'd0, wr_c}, {31'd0, v.wr});
      check({v.name, " reg_index"}, {26'd0, idx_c}, {26'd0, v.idx});
      if (v.wr) check({v.name, " wr_data"}, wd_c, v.wdata);
    end
    check({v.name, " stb count"}, stb_cnt, v.stb);
    if (v.stb != 0) check({v.name, " stb idx"}, {28'd0, sidx_c}, {28'd0, v.sidx});
    check({v.name, " undef"}, {31'd0, und_c}, {31'd0, v.undef});
    @(posedge i_clk); #1;
    check({v.name, " done width"}, {31'd0, o_copro_done}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs.push_back('{"mrc_cr0_r1",   mrc(4'd0, 4'd1),  MODE_USR, 32'd0,         2, 1, 1'b1, 6'd1,  CP_ID,         0, 4'd0, 1'b0});
    vecs.push_back('{"mrc_cr1_r4",   mrc(4'd1, 4'd4),  MODE_USR, 32'd0,         2, 1, 1'b1, 6'd4,  CTRL0,         0, 4'd0, 1'b0});
    vecs.push_back('{"mcr_r2_cr2",   mcr(4'd2, 4'd2),  MODE_USR, 32'hDEAD_BEEF, 3, 1, 1'b0, 6'd2,  32'd0,         1, 4'd2, 1'b0});
    vecs.push_back('{"mrc_cr2_r3",   mrc(4'd2, 4'd3),  MODE_USR, 32'd0,         2, 1, 1'b1, 6'd3,  32'hDEAD_BEEF, 0, 4'd0, 1'b0});
    vecs.push_back('{"mcr_cr0",      mcr(4'd0, 4'd0),  MODE_USR, 32'd0,         3, 1, 1'b0, 6'd0,  32'd0,         0, 4'd0, 1'b0});
    vecs.push_back('{"mrc_cr0_r5",   mrc(4'd0, 4'd5),  MODE_USR, 32'd0,         2, 1, 1'b1, 6'd5,  CP_ID,         0, 4'd0, 1'b0});
    vecs.push_back('{"fiq_r9",       mrc(4'd2, 4'd9),  MODE_FIQ, 32'd0,         2, 1, 1'b1, 6'd17, 32'hDEAD_BEEF, 0, 4'd0, 1'b0});
    vecs.push_back('{"fiq_r14",      mrc(4'd0, 4'd14), MODE_FIQ, 32'd0,         2, 1, 1'b1, 6'd22, CP_ID,         0, 4'd0, 1'b0});
    vecs.push_back('{"mrc_r15",      mrc(4'd0, 4'd15), MODE_USR, 32'd0,         2, 0, 1'b1, 6'd15, CP_ID,         0, 4'd0, 1'b0});
    vecs.push_back('{"cdp",          32'hEE00_0F00,    MODE_USR, 32'd0,         1, 0, 1'b0, 6'd0,  32'd0,         0, 4'd0, UNDEF_EXP});
    vecs.push_back('{"mcr_cp14",     32'hEE00_2E10,    MODE_USR, 32'd0,         1, 0, 1'b0, 6'd0,  32'd0,         0, 4'd0, UNDEF_EXP});
    vecs.push_back('{"ldc",          32'hED91_2F00,    MODE_USR, 32'd0,         1, 0, 1'b0, 6'd0,  32'd0,         0, 4'd0, UNDEF_EXP});
    vecs.push_back('{"mcr_r7_cr1",   mcr(4'd1, 4'd7),  MODE_SVC, 32'h0000_1234, 3, 1, 1'b0, 6'd7,  32'd0,         1, 4'd1, 1'b0});
    vecs.push_back('{"svc_r13",      mrc(4'd1, 4'd13), MODE_SVC, 32'd0,         2, 1, 1'b1, 6'd25, 32'h0000_1234, 0, 4'd0, 1'b0});
    vecs.push_back('{"irq_r14",      mrc(4'd3, 4'd14), MODE_IRQ, 32'd0,         2, 1, 1'b1, 6'd24, 32'd0,         0, 4'd0, 1'b0});
    vecs.push_back('{"abt_r13",      mrc(4'd3, 4'd13), MODE_ABT, 32'd0,         2, 1, 1'b1, 6'd27, 32'd0,         0, 4'd0, 1'b0});
    vecs.push_back('{"und_r14",      mrc(4'd3, 4'd14), MODE_UND, 32'd0,         2, 1, 1'b1, 6'd30, 32'd0,         0, 4'd0, 1'b0});
    vecs.push_back('{"sys_r13",      mrc(4'd3, 4'd13), MODE_SYS, 32'd0,         2, 1, 1'b1, 6'd13, 32'd0,         0, 4'd0, 1'b0});

    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check("reset ctrl", o_cp_ctrl, CTRL0);
    check("reset done", {31'd0, o_copro_done}, 32'd0);
    check("reset reg_en", {31'd0, o_reg_en}, 32'd0);
    check("reset reg_wr", {31'd0, o_reg_wr}, 32'd0);
    check("reset reg_index", {26'd0, o_reg_index}, 32'd0);
    check("reset wr_data", o_reg_wr_data, 32'd0);
    check("reset stb", {31'd0, o_cp_wr_stb}, 32'd0);
    check("reset stb idx", {28'd0, o_cp_wr_idx}, 32'd0);
    check("reset undef", {31'd0, o_undef}, 32'd0);

    foreach (vecs[i]) run_op(vecs[i], 1'b0);
    check("ctrl after mcr cr1", o_cp_ctrl, 32'h0000_1234);

    // dav dropped right after acceptance: the MCR still completes
    v = '{"mcr_drop_dav", mcr(4'd6, 4'd2), MODE_USR, 32'hCAFE_0006, 3, 1, 1'b0, 6'd2, 32'd0, 1, 4'd6, 1'b0};
    run_op(v, 1'b1);
    v = '{"mrc_cr6_r0", mrc(4'd6, 4'd0), MODE_USR, 32'd0, 2, 1, 1'b1, 6'd0, 32'hCAFE_0006, 0, 4'd0, 1'b0};
    run_op(v, 1'b0);

    // reset while the MCR to CR1 sits in CAPT
    i_copro_word  = mcr(4'd1, 4'd1);
    i_cpsr_mode   = MODE_USR;
    i_reg_rd_data = 32'hFFFF_FFFF;
    i_copro_dav   = 1'b1;
    @(posedge i_clk); #1;
    check("abort xfer reg_en", {31'd0, o_reg_en}, 32'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    i_copro_dav = 1'b0;
    @(posedge i_clk); #1;
    check("abort done", {31'd0, o_copro_done}, 32'd0);
    check("abort stb", {31'd0, o_cp_wr_stb}, 32'd0);
    check("abort ctrl", o_cp_ctrl, CTRL0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    check("post abort done", {31'd0, o_copro_done}, 32'd0);
    check("post abort stb", {31'd0, o_cp_wr_stb}, 32'd0);
    check("post abort ctrl", o_cp_ctrl, CTRL0);
    v = '{"mrc_after_abort", mrc(4'd1, 4'd1), MODE_USR, 32'd0, 2, 1, 1'b1, 6'd1, CTRL0, 0, 4'd0, 1'b0};
    run_op(v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
